maze_mem_arbiter: RTL and testbench
===================================

MAZE_MEM_ARBITER -- requirements
Module: maze_mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 8, maze-memory address width.
REQ-002 Parameter: DATA_W, 1, maze-memory word width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-high.
REQ-005 Port: req0, req1  input  1 each  access request from requester 0 (solver controller) and requester 1 (path replay unit).
REQ-006 Port: we0, we1  input  1 each  1 = write, 0 = read, per requester.
REQ-007 Port: addr0, addr1  input  ADDR_W each  access address, per requester.
REQ-008 Port: wdata0, wdata1  input  DATA_W each  write data, per requester.
REQ-009 Port: prio0  input  1  when high, requester 0 wins every contention.
REQ-010 Port: ack0, ack1  output  1 each  one-cycle completion pulse, per requester.
REQ-011 Port: rdata  output  DATA_W  registered read data, valid while ackN is high.
REQ-012 Port: gnt0, gnt1  output  1 each  high from ACCESS through DONE for the owning requester.
REQ-013 Port: busy  output  1  high in every state except IDLE.
REQ-014 Port: cen, WR, RD  output  1 each  memory chip enable, write strobe and read strobe.
REQ-015 Port: mem_addr  output  ADDR_W  and  mem_wdata  output  DATA_W  memory address and write data.
REQ-016 Port: mem_rdata  input  DATA_W  memory read data, valid the cycle after cen&RD.

Function
REQ-017 FSM states: IDLE, ACCESS, RESP, DONE; transitions IDLE->ACCESS when req0|req1, ACCESS->RESP, RESP->DONE and DONE->IDLE unconditionally.
REQ-018 In IDLE with exactly one request, that requester is selected.
REQ-019 In IDLE with both requests and prio0=1, requester 0 is selected.
REQ-020 In IDLE with both requests and prio0=0, the requester not served last is selected (round-robin); the last-served pointer updates in DONE.
REQ-021 In the IDLE->ACCESS transition: latch the selected id, we, addr and wdata into internal registers; later changes on requester inputs are ignored until DONE.
REQ-022 ACCESS: cen=1, WR=latched we, RD=~latched we, mem_addr and mem_wdata from the latched registers.
REQ-023 Outside ACCESS: cen=WR=RD=0; mem_addr and mem_wdata hold their last values.
REQ-024 RESP: on a read, capture mem_rdata into the rdata register at the end of the cycle; on a write, rdata is unchanged.
REQ-025 DONE: assert ack of the granted requester for exactly one cycle; the other ack stays 0.
REQ-026 Latency: request sampled in IDLE at cycle N gives memory strobe at N+1 and ack at N+3, for both reads and writes.
REQ-027 Throughput: at most one transaction per 4 cycles; a req still high in the IDLE cycle after DONE is a new transaction.
REQ-028 Requester protocol: hold req, we, addr and wdata stable until ack; deasserting req mid-transaction does not abort it, and its ack still pulses.
REQ-029 ack0&ack1, gnt0&gnt1 and WR&RD are never high together.

Reset
REQ-030 While rst=1, asynchronously: state=IDLE; all outputs 0 (ack0, ack1, gnt0, gnt1, busy, cen, WR, RD, mem_addr, mem_wdata, rdata); latched registers cleared; last-served pointer=1, so requester 0 wins the first round-robin contest.
REQ-031 Reset asserted mid-transaction aborts the transaction: no ack is issued and no memory strobe follows release.
REQ-032 After rst deasserts, the first request is sampled on the first rising edge.

Verification
REQ-033 Single read: req0=1, we0=0, addr0=8'h23, mem returns 1 -> cen&RD high at N+1 with mem_addr=8'h23; ack0=1 with rdata=1 at N+3; ack1 stays 0.
REQ-034 Single write: req1=1, we1=1, addr1=8'h5A, wdata1=1 -> cen&WR high at N+1 with mem_addr=8'h5A, mem_wdata=1; ack1 at N+3; rdata unchanged.
REQ-035 Round-robin: req0 and req1 held high, prio0=0, from reset -> grant order 0,1,0,1; acks at cycles 3, 7, 11, 15.
REQ-036 Priority: req0 and req1 held high, prio0=1 -> only requester 0 is served; req1 starves and ack1 never asserts while req0 stays high.
REQ-037 Reset mid-op: rst pulsed during RESP -> all outputs 0 immediately, no ack, busy=0; next req0 completes normally at N+3.
REQ-038 Input change: addr0 changed from 8'h10 to 8'h20 during ACCESS -> mem_addr stays 8'h10; single ack0.

Source files
------------

// File: rtl/maze_mem_arbiter.sv
// Two-requester arbiter for the single-port maze memory.
// Requester 0 is the solver controller and requester 1 is the path replay unit.
// Each transaction takes four cycles: IDLE -> ACCESS -> RESP -> DONE.
// When both request at once, prio0 gives requester 0 a fixed win;
// otherwise the requester that was not served last wins.
module maze_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              prio0,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              gnt0,
  output logic              gnt1,
  output logic              busy,
  output logic              cen,
  output logic              WR,
  output logic              RD,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, DONE} state_t;

  state_t              state_q, state_d;
  logic                id_q, id_d;        // owning requester of the current transaction
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                last_q, last_d;    // requester served most recently
  logic                sel_id;

  // Pick a winner among the current requests.
  always_comb begin
    sel_id = 1'b0;
    if (req0 && req1) begin
      sel_id = prio0 ? 1'b0 : ~last_q;
    end else if (req1) begin
      sel_id = 1'b1;
    end
  end

  // Next-state logic, transaction latching and read-data capture.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = ACCESS;
          id_d    = sel_id;
          we_d    = sel_id ? we1    : we0;
          addr_d  = sel_id ? addr1  : addr0;
          wdata_d = sel_id ? wdata1 : wdata0;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        state_d = DONE;
        if (!we_q) rdata_d = mem_rdata;
      end
      DONE: begin
        state_d = IDLE;
        last_d  = id_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched-transaction registers. A reset mid-transaction abandons the transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      last_q  <= last_d;
    end
  end

  // Outputs are decoded from registered state only.
  // mem_addr and mem_wdata come straight from the latched registers, so they keep their value between accesses.
  always_comb begin
    busy      = (state_q != IDLE);
    gnt0      = busy && !id_q;
    gnt1      = busy &&  id_q;
    ack0      = (state_q == DONE) && !id_q;
    ack1      = (state_q == DONE) &&  id_q;
    cen       = (state_q == ACCESS);
    WR        = cen &&  we_q;
    RD        = cen && !we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    rdata     = rdata_q;
  end

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Directed testbench for maze_mem_arbiter.
// A small behavioural memory model sits behind the arbiter.
module tb_maze_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, we0, we1, prio0;
  logic [7:0] addr0, addr1;
  logic       wdata0, wdata1;
  logic       ack0, ack1, gnt0, gnt1, busy, cen, WR, RD;
  logic       rdata, mem_wdata;
  logic       mem_rdata;
  logic [7:0] mem_addr;

  int checks   = 0;
  int failures = 0;
  int n_ack0, n_ack1;

  logic mem [256];

  maze_mem_arbiter #(.ADDR_W(8), .DATA_W(1)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .prio0(prio0),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .gnt0(gnt0), .gnt1(gnt1),
    .busy(busy), .cen(cen), .WR(WR), .RD(RD),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural memory: synchronous write, read data valid the cycle after cen&RD.
  always @(posedge clk) begin
    if (cen && WR) mem[mem_addr] <= mem_wdata;
    if (cen && RD) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 8) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 1'b0;
    mem[8'h23] = 1'b1;
    mem[8'h45] = 1'b1;
    mem_rdata = 1'b0;
    rst = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; prio0 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    tick(); tick();
    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cen", 32'(cen), 32'd0);
    check("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
    check("rst_ack", 32'({ack0, ack1}), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    rst = 1'b0;

    // Single read by requester 0
    req0 = 1; we0 = 0; addr0 = 8'h23;
    tick();
    check("rd_cen", 32'({cen, RD, WR}), 32'b110);
    check("rd_addr", 32'(mem_addr), 32'h23);
    check("rd_gnt", 32'({gnt0, gnt1}), 32'b10);
    tick();
    check("rd_resp_cen", 32'(cen), 32'd0);
    check("rd_resp_ack", 32'({ack0, ack1}), 32'd0);
    tick();
    check("rd_ack", 32'({ack0, ack1}), 32'b10);
    check("rd_rdata", 32'(rdata), 32'd1);
    req0 = 0;
    tick();
    check("rd_after_ack", 32'({ack0, busy}), 32'd0);
    check("rd_addr_hold", 32'(mem_addr), 32'h23);

    // Single write by requester 1
    req1 = 1; we1 = 1; addr1 = 8'h5A; wdata1 = 1;
    tick();
    check("wr_strobe", 32'({cen, WR, RD}), 32'b110);
    check("wr_addr", 32'(mem_addr), 32'h5A);
    check("wr_wdata", 32'(mem_wdata), 32'd1);
    check("wr_gnt", 32'({gnt0, gnt1}), 32'b01);
    tick(); tick();
    check("wr_ack", 32'({ack0, ack1}), 32'b01);
    check("wr_rdata_kept", 32'(rdata), 32'd1);
    req1 = 0; we1 = 0; wdata1 = 0;
    tick();
    check("wr_mem", 32'(mem[8'h5A]), 32'd1);

    // Round-robin from reset: requester 0 first, acks at cycles 3, 7, 11, 15
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 8'h23; addr1 = 8'h24; prio0 = 0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("rr_ack0_c%0d", i), 32'(ack0), 32'((i == 3) || (i == 11)));
      check($sformatf("rr_ack1_c%0d", i), 32'(ack1), 32'((i == 7) || (i == 15)));
      tick();
    end

    // Fixed priority: requester 1 starves
    prio0 = 1;
    n_ack0 = 0; n_ack1 = 0;
    for (int i = 0; i < 16; i++) begin
      n_ack0 += int'(ack0);
      n_ack1 += int'(ack1);
      if (gnt1 || (WR && RD)) check("prio_gnt1_or_strobes", 32'd1, 32'd0);
      tick();
    end
    check("prio_ack0_count", 32'(n_ack0), 32'd4);
    check("prio_ack1_count", 32'(n_ack1), 32'd0);

    // Reset during RESP aborts the transaction
    req0 = 0; req1 = 0; prio0 = 0;
    wait_idle();
    req0 = 1; we0 = 0; addr0 = 8'h44;
    tick(); tick();
    rst = 1'b1;
    #1;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_gnt", 32'({gnt0, gnt1}), 32'd0);
    check("rstmid_ack", 32'({ack0, ack1}), 32'd0);
    check("rstmid_rdata", 32'(rdata), 32'd0);
    check("rstmid_addr", 32'(mem_addr), 32'd0);
    req0 = 0;
    tick();
    rst = 1'b0;
    n_ack0 = 0;
    for (int i = 0; i < 4; i++) begin
      n_ack0 += int'(ack0 | ack1 | cen);
      tick();
    end
    check("rstmid_no_ack", 32'(n_ack0), 32'd0);
    req0 = 1; we0 = 0; addr0 = 8'h45;
    tick();
    check("rstmid_new_strobe", 32'({cen, RD}), 32'b11);
    tick(); tick();
    check("rstmid_new_ack", 32'(ack0), 32'd1);
    check("rstmid_new_rdata", 32'(rdata), 32'd1);
    req0 = 0;
    tick();

    // A change on addr0 during ACCESS is ignored
    req0 = 1; we0 = 0; addr0 = 8'h10;
    tick();
    addr0 = 8'h20;
    #1;
    check("inchg_access_addr", 32'(mem_addr), 32'h10);
    n_ack0 = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 1) req0 = 0;
      n_ack0 += int'(ack0);
    end
    check("inchg_hold_addr", 32'(mem_addr), 32'h10);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_ack0 += int'(ack0);
    end
    check("inchg_ack_count", 32'(n_ack0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
